// File: rtl/mem_access_unit_if.sv
// Data-memory handshake between the MEM-stage load/store unit (master) and the data memory (slave).
interface mem_access_unit_if;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTEEN;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_BUSYWAIT;

  modport master (
    output DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTEEN,
    input  DMEM_READDATA, DMEM_BUSYWAIT
  );

  modport slave (
    input  DMEM_READ, DMEM_WRITE, DMEM_ADDR, DMEM_WRITEDATA, DMEM_BYTEEN,
    output DMEM_READDATA, DMEM_BUSYWAIT
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane steering, load extension, data-memory handshake and pipeline stall.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing natural alignment.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        IN_READ_WRITE,
  input  logic [31:0]       IN_ALU_RESULT,
  input  logic [31:0]       IN_DATA2,
  mem_access_unit_if.master dmem,
  output logic [31:0]       LOAD_DATA,
  output logic              BUSYWAIT,
  output logic              MEM_ERROR
);
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       op_p0;
  logic [1:0]       lane_p0;

  logic       is_load, is_store, is_half, is_word, go;
  logic [1:0] lane;
`ifdef MEM_MISALIGN_TRAP_EN
  logic       misaligned;
`endif

  function automatic logic [3:0] byte_en(input logic store, input logic half,
                                         input logic word, input logic [1:0] ln);
    if (!store || word) return 4'b1111;
    if (half) return 4'b0011 << ln;
    return 4'b0001 << ln;
  endfunction

  function automatic logic [31:0] store_data(input logic half, input logic word,
                                             input logic [31:0] d);
    if (word) return d;
    if (half) return {2{d[15:0]}};
    return {4{d[7:0]}};
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] ln,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (op)
      4'b0001: return 32'(signed'(b));
      4'b0010: return 32'(signed'(h));
      4'b0100: return 32'(b);
      4'b0101: return 32'(h);
      default: return word;
    endcase
  endfunction

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (IN_READ_WRITE)
      4'b0001, 4'b0100: is_load = 1'b1;
      4'b0010, 4'b0101: begin is_load = 1'b1; is_half = 1'b1; end
      4'b0011:          begin is_load = 1'b1; is_word = 1'b1; end
      4'b1001:          is_store = 1'b1;
      4'b1010:          begin is_store = 1'b1; is_half = 1'b1; end
      4'b1011:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = (is_half && IN_ALU_RESULT[0]) || (is_word && IN_ALU_RESULT[1:0] != 2'b00);
    lane       = IN_ALU_RESULT[1:0];
    go         = (is_load || is_store) && !misaligned;
`else
    // Misaligned low bits are silently dropped to the natural boundary.
    lane = is_word ? 2'b00 : (is_half ? {IN_ALU_RESULT[1], 1'b0} : IN_ALU_RESULT[1:0]);
    go   = is_load || is_store;
`endif
  end

  assign BUSYWAIT = !RESET && ((state == IDLE && go) || state == ACCESS);

  // Access descriptor, needed only to extend the returned word
  always_ff @(posedge CLK) begin
    if (state == IDLE && go) begin
      op_p0   <= IN_READ_WRITE;
      lane_p0 <= lane;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      dmem.DMEM_READ      <= 1'b0;
      dmem.DMEM_WRITE     <= 1'b0;
      dmem.DMEM_ADDR      <= '0;
      dmem.DMEM_WRITEDATA <= '0;
      dmem.DMEM_BYTEEN    <= '0;
      LOAD_DATA           <= '0;
      MEM_ERROR           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MEM_ERROR <= 1'b0;
          if (go) begin
            state               <= ACCESS;
            wait_cnt            <= '0;
            dmem.DMEM_READ      <= is_load;
            dmem.DMEM_WRITE     <= is_store;
            dmem.DMEM_ADDR      <= {IN_ALU_RESULT[31:2], 2'b00};
            dmem.DMEM_WRITEDATA <= store_data(is_half, is_word, IN_DATA2);
            dmem.DMEM_BYTEEN    <= byte_en(is_store, is_half, is_word, lane);
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (misaligned) begin
            state     <= DONE;
            MEM_ERROR <= 1'b1;
          end
`endif
        end
        ACCESS: begin
          if (!dmem.DMEM_BUSYWAIT) begin
            dmem.DMEM_READ  <= 1'b0;
            dmem.DMEM_WRITE <= 1'b0;
            if (dmem.DMEM_READ) LOAD_DATA <= load_extend(op_p0, lane_p0, dmem.DMEM_READDATA);
            state <= DONE;
          end else if (MAX_WAIT > 0 && wait_cnt == CNT_LAST) begin
            // Watchdog abort: the load result is deliberately left stale.
            dmem.DMEM_READ  <= 1'b0;
            dmem.DMEM_WRITE <= 1'b0;
            MEM_ERROR       <= 1'b1;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          MEM_ERROR <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (MAX_WAIT=4); expectations follow MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  IN_READ_WRITE;
  logic [31:0] IN_ALU_RESULT;
  logic [31:0] IN_DATA2;
  logic [31:0] LOAD_DATA;
  logic        BUSYWAIT;
  logic        MEM_ERROR;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if dmem();

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IN_READ_WRITE(IN_READ_WRITE),
    .IN_ALU_RESULT(IN_ALU_RESULT),
    .IN_DATA2     (IN_DATA2),
    .dmem         (dmem),
    .LOAD_DATA    (LOAD_DATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_ERROR    (MEM_ERROR)
  );

  always #5 CLK = ~CLK;

  // Memory model: busy for the first 'lat' strobe cycles of each access.
  int          lat   = 0;
  int          mcnt  = 0;
  logic [31:0] rdata = '0;
  assign dmem.DMEM_READDATA = rdata;
  assign dmem.DMEM_BUSYWAIT = (dmem.DMEM_READ || dmem.DMEM_WRITE) && (mcnt < lat);
  always @(posedge CLK) mcnt <= (dmem.DMEM_READ || dmem.DMEM_WRITE) ? mcnt + 1 : 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic [31:0] ld;
    logic        err;
    int          busy;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                              input logic rd, input logic wr, input logic [31:0] ld,
                              input logic err, input int busy);
    exp_t e;
    e.addr = addr; e.wdata = wdata; e.be = be; e.rd = rd; e.wr = wr;
    e.ld = ld; e.err = err; e.busy = busy;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after a later negedge with the unit idle.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int lt, input exp_t e);
    exp_t        x;
    int          busy;
    logic        req, done, o_rd, o_wr;
    logic [31:0] o_addr, o_wd;
    logic [3:0]  o_be;
    exp_q.push_back(e);
    IN_READ_WRITE = op; IN_ALU_RESULT = a; IN_DATA2 = d; rdata = rd; lat = lt;
    busy = 0; req = 1'b0; done = 1'b0; o_rd = 1'b0; o_wr = 1'b0;
    o_addr = '0; o_wd = '0; o_be = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      #2;
      if (!req && (dmem.DMEM_READ || dmem.DMEM_WRITE)) begin
        req = 1'b1; o_rd = dmem.DMEM_READ; o_wr = dmem.DMEM_WRITE;
        o_addr = dmem.DMEM_ADDR; o_wd = dmem.DMEM_WRITEDATA; o_be = dmem.DMEM_BYTEEN;
      end
      if (!BUSYWAIT) done = 1'b1;
      else begin
        busy++;
        @(negedge CLK);
      end
    end
    x = exp_q.pop_front();
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " busy_cycles"}, 32'(busy), 32'(x.busy));
    chk({tag, " read"}, 32'(o_rd), 32'(x.rd));
    chk({tag, " write"}, 32'(o_wr), 32'(x.wr));
    if (x.rd || x.wr) begin
      chk({tag, " addr"}, o_addr, x.addr);
      chk({tag, " byteen"}, 32'(o_be), 32'(x.be));
    end
    if (x.wr) chk({tag, " wdata"}, o_wd, x.wdata);
    if (x.busy == 0) begin
      IN_READ_WRITE = 4'b0000;
      @(negedge CLK); #2;
    end
    chk({tag, " mem_error"}, 32'(MEM_ERROR), 32'(x.err));
    chk({tag, " load_data"}, LOAD_DATA, x.ld);
    chk({tag, " strobes_dropped"}, 32'(dmem.DMEM_READ || dmem.DMEM_WRITE), 32'd0);
    IN_READ_WRITE = 4'b0000;
    @(negedge CLK); #2;
    chk({tag, " error_pulse_end"}, 32'(MEM_ERROR), 32'd0);
    chk({tag, " idle_busywait"}, 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
  endtask

  logic [31:0] ld_exp;

  initial begin
    RESET = 1'b1; IN_READ_WRITE = 4'b0000; IN_ALU_RESULT = '0; IN_DATA2 = '0;
    @(negedge CLK); @(negedge CLK); #2;
    chk("reset read", 32'(dmem.DMEM_READ), 32'd0);
    chk("reset write", 32'(dmem.DMEM_WRITE), 32'd0);
    chk("reset addr", dmem.DMEM_ADDR, 32'd0);
    chk("reset byteen", 32'(dmem.DMEM_BYTEEN), 32'd0);
    chk("reset load_data", LOAD_DATA, 32'd0);
    chk("reset mem_error", 32'(MEM_ERROR), 32'd0);
    chk("reset busywait", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK);

    do_op("lb_103", 4'b0001, 32'h103, 32'h0, 32'h80FF_1234, 2,
          mk(32'h100, 32'h0, 4'b1111, 1, 0, 32'hFFFF_FF80, 0, 4));
    do_op("lhu_202", 4'b0101, 32'h202, 32'h0, 32'h9ABC_5678, 0,
          mk(32'h200, 32'h0, 4'b1111, 1, 0, 32'h0000_9ABC, 0, 2));
    do_op("lh_202", 4'b0010, 32'h202, 32'h0, 32'h9ABC_5678, 1,
          mk(32'h200, 32'h0, 4'b1111, 1, 0, 32'hFFFF_9ABC, 0, 3));
    do_op("lbu_101", 4'b0100, 32'h101, 32'h0, 32'h0000_8000, 0,
          mk(32'h100, 32'h0, 4'b1111, 1, 0, 32'h0000_0080, 0, 2));
    do_op("lb_102_pos", 4'b0001, 32'h102, 32'h0, 32'h007F_0000, 1,
          mk(32'h100, 32'h0, 4'b1111, 1, 0, 32'h0000_007F, 0, 3));
    do_op("sb_301", 4'b1001, 32'h301, 32'h0000_00A5, 32'h0, 1,
          mk(32'h300, 32'hA5A5_A5A5, 4'b0010, 0, 1, 32'h0000_007F, 0, 3));
    do_op("sh_302", 4'b1010, 32'h302, 32'h1234_BEEF, 32'h0, 0,
          mk(32'h300, 32'hBEEF_BEEF, 4'b1100, 0, 1, 32'h0000_007F, 0, 2));
    do_op("sb_300", 4'b1001, 32'h300, 32'h0000_003C, 32'h0, 0,
          mk(32'h300, 32'h3C3C_3C3C, 4'b0001, 0, 1, 32'h0000_007F, 0, 2));
    do_op("sw_stuck", 4'b1011, 32'h304, 32'hDEAD_BEEF, 32'h0, 1000,
          mk(32'h304, 32'hDEAD_BEEF, 4'b1111, 0, 1, 32'h0000_007F, 1, 5));
    do_op("lw_stuck", 4'b0011, 32'h700, 32'h0, 32'hFFFF_FFFF, 1000,
          mk(32'h700, 32'h0, 4'b1111, 1, 0, 32'h0000_007F, 1, 5));
`ifdef MEM_MISALIGN_TRAP_EN
    do_op("lw_402", 4'b0011, 32'h402, 32'h0, 32'hCAFE_F00D, 0,
          mk(32'h0, 32'h0, 4'b0000, 0, 0, 32'h0000_007F, 1, 0));
    do_op("lh_203", 4'b0010, 32'h203, 32'h0, 32'h9ABC_5678, 0,
          mk(32'h0, 32'h0, 4'b0000, 0, 0, 32'h0000_007F, 1, 0));
    do_op("sw_306", 4'b1011, 32'h306, 32'h0102_0304, 32'h0, 0,
          mk(32'h0, 32'h0, 4'b0000, 0, 0, 32'h0000_007F, 1, 0));
    ld_exp = 32'h0000_007F;
`else
    do_op("lw_402", 4'b0011, 32'h402, 32'h0, 32'hCAFE_F00D, 0,
          mk(32'h400, 32'h0, 4'b1111, 1, 0, 32'hCAFE_F00D, 0, 2));
    do_op("lh_203", 4'b0010, 32'h203, 32'h0, 32'h9ABC_5678, 0,
          mk(32'h200, 32'h0, 4'b1111, 1, 0, 32'hFFFF_9ABC, 0, 2));
    do_op("sw_306", 4'b1011, 32'h306, 32'h0102_0304, 32'h0, 0,
          mk(32'h304, 32'h0102_0304, 4'b1111, 0, 1, 32'hFFFF_9ABC, 0, 2));
    ld_exp = 32'hFFFF_9ABC;
`endif
    do_op("invalid_op", 4'b0110, 32'h500, 32'h0, 32'h0, 0,
          mk(32'h0, 32'h0, 4'b0000, 0, 0, ld_exp, 0, 0));

    // Reset during the ACCESS phase of a load that never completes
    IN_READ_WRITE = 4'b0011; IN_ALU_RESULT = 32'h800; rdata = 32'h5555_AAAA; lat = 1000;
    @(negedge CLK); @(negedge CLK); #2;
    chk("rst_mid read_before", 32'(dmem.DMEM_READ), 32'd1);
    RESET = 1'b1; #1;
    chk("rst_mid read", 32'(dmem.DMEM_READ), 32'd0);
    chk("rst_mid busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mid load_data", LOAD_DATA, 32'd0);
    IN_READ_WRITE = 4'b0000;
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); #2;
    chk("rst_mid idle_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mid idle_read", 32'(dmem.DMEM_READ), 32'd0);
    @(negedge CLK);

    do_op("lw_600_after_rst", 4'b0011, 32'h600, 32'h0, 32'h1234_5678, 1,
          mk(32'h600, 32'h0, 4'b1111, 1, 0, 32'h1234_5678, 0, 3));

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
